// File: rtl/stack_guarded.sv
// Guarded LIFO stack with signed SP step, second-of-stack read, occupancy and sticky error flags.
// Optional high-water mark register enabled by defining STACK_WATERMARK_EN.
module stack_guarded #(
   parameter int SADDR_WIDTH = 8,
   parameter int WIDTH       = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wait_state,
   input  logic [1:0]             delta,
   input  logic                   wr,
   input  logic [WIDTH-1:0]       D,
   input  logic                   clr_err,
   output logic [WIDTH-1:0]       Q,
   output logic [WIDTH-1:0]       Q1,
   output logic [SADDR_WIDTH:0]   depth,
   output logic                   full,
   output logic                   empty,
   output logic                   ovf,
   output logic                   unf,
   output logic [SADDR_WIDTH:0]   hwm
);

   localparam logic [SADDR_WIDTH:0] DEPTH_C = {1'b1, {SADDR_WIDTH{1'b0}}};

   logic [WIDTH-1:0]       mem [0:(1<<SADDR_WIDTH)-1];
   logic [SADDR_WIDTH-1:0] sp_q, sp_d;
   logic [SADDR_WIDTH:0]   depth_q, depth_d;
   logic                   ovf_q, ovf_d;
   logic                   unf_q, unf_d;
   logic [SADDR_WIDTH:0]   delta_ext_s;
   logic [SADDR_WIDTH-1:0] nsp_s;
   logic [SADDR_WIDTH-1:0] sp_m1_s;
   logic [SADDR_WIDTH:0]   ndepth_s;
   logic                   ovf_hit_s;
   logic                   unf_hit_s;
   logic                   commit_s;

   assign delta_ext_s = {{(SADDR_WIDTH-1){delta[1]}}, delta};
   assign nsp_s       = sp_q + delta_ext_s[SADDR_WIDTH-1:0];
   assign ndepth_s    = depth_q + delta_ext_s;
   assign sp_m1_s     = sp_q - SADDR_WIDTH'(1);

   // Guard evaluation: a rejected op must not move SP nor write memory.
   always_comb begin
      ovf_hit_s = 1'b0;
      unf_hit_s = 1'b0;
      case (delta)
         2'b01:   ovf_hit_s = (depth_q == DEPTH_C);
         2'b11:   unf_hit_s = (depth_q < (SADDR_WIDTH+1)'(1));
         2'b10:   unf_hit_s = (depth_q < (SADDR_WIDTH+1)'(2));
         2'b00:   unf_hit_s = wr && (depth_q == '0);
         default: begin
            ovf_hit_s = 1'b0;
            unf_hit_s = 1'b0;
         end
      endcase
      commit_s = !wait_state && !ovf_hit_s && !unf_hit_s;
   end

   // Next-state for SP, occupancy and sticky flags; a new error beats clr_err.
   always_comb begin
      sp_d    = sp_q;
      depth_d = depth_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      if (commit_s) begin
         sp_d    = nsp_s;
         depth_d = ndepth_s;
      end else begin
         sp_d    = sp_q;
         depth_d = depth_q;
      end
      if (!wait_state) begin
         ovf_d = ovf_hit_s || (ovf_q && !clr_err);
         unf_d = unf_hit_s || (unf_q && !clr_err);
      end else begin
         ovf_d = ovf_q;
         unf_d = unf_q;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sp_q    <= '0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         sp_q    <= sp_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Storage array; contents survive reset.
   always_ff @(posedge clk) begin
      if (!reset && commit_s && wr) begin
         mem[nsp_s] <= D;
      end
   end

`ifdef STACK_WATERMARK_EN
   logic [SADDR_WIDTH:0] hwm_q, hwm_d;

   // Peak occupancy seen on committed ops.
   always_comb begin
      hwm_d = hwm_q;
      if (commit_s && (ndepth_s > hwm_q)) begin
         hwm_d = ndepth_s;
      end else begin
         hwm_d = hwm_q;
      end
   end

   // High-water mark register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         hwm_q <= '0;
      end else begin
         hwm_q <= hwm_d;
      end
   end

   assign hwm = hwm_q;
`else
   assign hwm = '0;
`endif

   assign Q     = (depth_q == '0) ? '0 : mem[sp_q];
   assign Q1    = (depth_q < (SADDR_WIDTH+1)'(2)) ? '0 : mem[sp_m1_s];
   assign depth = depth_q;
   assign full  = (depth_q == DEPTH_C);
   assign empty = (depth_q == '0);
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule

// File: tb/tb_stack_guarded.sv
// Randomised self-checking bench for stack_guarded against a spec-level stack model.
// Honours STACK_WATERMARK_EN for the expected hwm value.
module tb_stack_guarded;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wait_state = 1'b0;
   logic [1:0]  delta = 2'b00;
   logic        wr = 1'b0;
   logic [15:0] D = 16'h0000;
   logic        clr_err = 1'b0;
   logic [15:0] Q, Q1;
   logic [8:0]  depth, hwm;
   logic        full, empty, ovf, unf;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference: an array of 256 cells, a top pointer and an occupancy count.
   logic [15:0] m_mem [256];
   int          m_sp = 0, m_depth = 0, m_hwm = 0;
   bit          m_ovf = 1'b0, m_unf = 1'b0;

   stack_guarded #(.SADDR_WIDTH(8), .WIDTH(16)) dut (
      .clk(clk), .reset(reset), .wait_state(wait_state), .delta(delta), .wr(wr),
      .D(D), .clr_err(clr_err), .Q(Q), .Q1(Q1), .depth(depth), .full(full),
      .empty(empty), .ovf(ovf), .unf(unf), .hwm(hwm)
   );

   always #5 clk = ~clk;

   // Model update on the active edge.
   always @(posedge clk) begin
      automatic int dv = 0;
      automatic int nd = 0;
      automatic int nsp = 0;
      automatic bit o = 1'b0;
      automatic bit u = 1'b0;
      if (reset) begin
         m_sp <= 0; m_depth <= 0; m_hwm <= 0; m_ovf <= 1'b0; m_unf <= 1'b0;
      end else if (!wait_state) begin
         dv  = (delta == 2'b01) ? 1 : (delta == 2'b11) ? -1 : (delta == 2'b10) ? -2 : 0;
         nd  = m_depth + dv;
         o   = (dv == 1) && (m_depth == 256);
         u   = (nd < 0) || (wr && dv == 0 && m_depth == 0);
         nsp = (m_sp + dv + 256) % 256;
         if (!o && !u) begin
            m_sp <= nsp;
            m_depth <= nd;
            if (wr) m_mem[nsp] <= D;
`ifdef STACK_WATERMARK_EN
            if (nd > m_hwm) m_hwm <= nd;
`endif
         end
         m_ovf <= o | (m_ovf & ~clr_err);
         m_unf <= u | (m_unf & ~clr_err);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Compare every output against the model on the inactive edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("Q", 32'(Q), (m_depth == 0) ? 32'd0 : 32'(m_mem[m_sp]));
         chk("Q1", 32'(Q1), (m_depth < 2) ? 32'd0 : 32'(m_mem[(m_sp + 255) % 256]));
         chk("depth", 32'(depth), 32'(m_depth));
         chk("full", 32'(full), 32'(m_depth == 256));
         chk("empty", 32'(empty), 32'(m_depth == 0));
         chk("ovf", 32'(ovf), 32'(m_ovf));
         chk("unf", 32'(unf), 32'(m_unf));
         chk("hwm", 32'(hwm), 32'(m_hwm));
      end
   end

   task automatic op(input logic [1:0] dl, input logic w, input logic [15:0] dat, input logic clr);
      delta = dl; wr = w; D = dat; clr_err = clr;
      @(negedge clk);
      delta = 2'b00; wr = 1'b0; clr_err = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      automatic int p = 0;
      automatic logic [1:0] dl = 2'b00;
      automatic logic [31:0] exp_hwm5 = 32'd0;
`ifdef STACK_WATERMARK_EN
      exp_hwm5 = 32'd5;
`endif
      do_reset();
      chk_en = 1'b1;
      chk("rst_depth", 32'(depth), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_Q", 32'(Q), 32'd0);

      // Watermark: push 5, pop 3.
      for (int i = 0; i < 5; i++) op(2'b01, 1'b1, 16'(i + 1), 1'b0);
      for (int i = 0; i < 3; i++) op(2'b11, 1'b0, 16'h0000, 1'b0);
      chk("wm_depth", 32'(depth), 32'd2);
      chk("wm_hwm", 32'(hwm), exp_hwm5);
      chk("wm_Q", 32'(Q), 32'h2);

      do_reset();
      op(2'b01, 1'b1, 16'h00A1, 1'b0);
      op(2'b01, 1'b1, 16'h00B2, 1'b0);
      op(2'b01, 1'b1, 16'h00C3, 1'b0);
      chk("push_Q", 32'(Q), 32'hC3);
      chk("push_Q1", 32'(Q1), 32'hB2);
      chk("push_depth", 32'(depth), 32'd3);
      chk("push_empty", 32'(empty), 32'd0);

      op(2'b00, 1'b1, 16'h0055, 1'b0);
      chk("repl_Q", 32'(Q), 32'h55);
      chk("repl_Q1", 32'(Q1), 32'hB2);
      chk("repl_depth", 32'(depth), 32'd3);
      op(2'b10, 1'b0, 16'h0000, 1'b0);
      chk("pop2_depth", 32'(depth), 32'd1);
      chk("pop2_Q", 32'(Q), 32'hA1);
      chk("pop2_Q1", 32'(Q1), 32'h0);

      op(2'b10, 1'b1, 16'h1234, 1'b0);
      chk("unf_flag", 32'(unf), 32'd1);
      chk("unf_depth", 32'(depth), 32'd1);
      chk("unf_Q", 32'(Q), 32'hA1);
      op(2'b00, 1'b0, 16'h0000, 1'b1);
      chk("unf_clr", 32'(unf), 32'd0);
      op(2'b11, 1'b0, 16'h0000, 1'b0);
      chk("pop_empty", 32'(empty), 32'd1);
      op(2'b00, 1'b1, 16'h0077, 1'b0);
      chk("unf_wr0", 32'(unf), 32'd1);
      chk("unf_wr0_depth", 32'(depth), 32'd0);
      op(2'b00, 1'b0, 16'h0000, 1'b1);

      // Stalled push, then release.
      wait_state = 1'b1; delta = 2'b01; wr = 1'b1; D = 16'h009A;
      repeat (4) @(negedge clk);
      chk("wait_depth", 32'(depth), 32'd0);
      chk("wait_Q", 32'(Q), 32'h0);
      wait_state = 1'b0;
      @(negedge clk);
      delta = 2'b00; wr = 1'b0;
      chk("rel_depth", 32'(depth), 32'd1);
      chk("rel_Q", 32'(Q), 32'h9A);

      // Fill to capacity and overflow.
      for (int i = 0; i < 255; i++) op(2'b01, 1'b1, 16'(i), 1'b0);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_depth", 32'(depth), 32'd256);
      chk("fill_Q", 32'(Q), 32'hFE);
      op(2'b01, 1'b1, 16'h00FF, 1'b0);
      chk("ovf_flag", 32'(ovf), 32'd1);
      chk("ovf_depth", 32'(depth), 32'd256);
      chk("ovf_Q", 32'(Q), 32'hFE);
      op(2'b01, 1'b1, 16'h00FF, 1'b1);
      chk("ovf_setwins", 32'(ovf), 32'd1);
      op(2'b00, 1'b0, 16'h0000, 1'b1);
      chk("ovf_clr", 32'(ovf), 32'd0);
      chk("ovf_clr_full", 32'(full), 32'd1);

      // Random phase alternating pop-heavy and push-heavy windows.
      for (int i = 0; i < 4000; i++) begin
         p = $urandom_range(0, 9);
         if (((i / 400) % 2) == 0)
            dl = (p < 2) ? 2'b01 : (p < 4) ? 2'b00 : (p < 7) ? 2'b11 : 2'b10;
         else
            dl = (p < 6) ? 2'b01 : (p < 8) ? 2'b00 : (p == 8) ? 2'b11 : 2'b10;
         delta = dl;
         wr = ($urandom_range(0, 9) < 7);
         D = 16'($urandom);
         clr_err = ($urandom_range(0, 19) == 0);
         wait_state = ($urandom_range(0, 9) == 0);
         reset = ($urandom_range(0, 999) == 0);
         @(negedge clk);
      end
      reset = 1'b0; wait_state = 1'b0; delta = 2'b00; wr = 1'b0; clr_err = 1'b0;
      @(negedge clk);
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
